picoblaze_rx_mailbox: RTL
=========================

Name: picoblaze_rx_mailbox

Overview:
- Responder/peripheral on the KCPSM3 (pacoblaze3) I/O port bus: the device end of port_id/read_strobe/write_strobe/in_port/out_port/interrupt/interrupt_ack.
- Buffers a byte stream from fabric logic in a FIFO and presents it to the processor through four I/O ports.
- Raises interrupt on fill threshold or overflow; holds it until interrupt_ack.
- Instantiated beside the processor; its in_port feeds the processor's input mux.

Parameters:
- BASE_ADDR, 8'h00, port block base; bits [1:0] must be 0; decode is port_id[7:2]==BASE_ADDR[7:2].
- DEPTH, 16, FIFO depth in bytes; power of two, 2..128.
- THRESH_RST, 8'd1, reset value of the threshold register.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- port_id  in  8  processor port address
- write_strobe  in  1  processor write qualifier
- read_strobe  in  1  processor read qualifier
- out_port  in  8  processor write data
- in_port  out  8  registered read data to processor
- interrupt  out  1  interrupt request to processor
- interrupt_ack  in  1  processor interrupt acknowledge
- in_valid  in  1  producer byte valid
- in_data  in  8  producer byte
- in_ready  out  1  producer may push; equals !full

Behaviour:
- Reset: FIFO empty; in_port=0; interrupt=0; irq_en=0; overflow=0; underflow=0; thresh=THRESH_RST; in_ready=1.
- Register map, offset from BASE_ADDR:
  - +0 DATA. Read returns the FIFO head. The pop occurs on read_strobe. Writes are ignored.
  - +1 STATUS. Read returns {overflow, underflow, irq_en, interrupt, 2'b0, full, empty}.
  - +1 CTRL, write-only, shares the STATUS address. bit0 = irq_en. bit1 = flush (self-clearing). bit2 = clear overflow. bit3 = clear underflow.
  - +2 COUNT. Read returns the occupancy, 0..DEPTH, zero-extended. Writes are ignored.
  - +3 THRESH. Read/write, 8 bits.
- Read path:
  - in_port is registered every cycle from the current port_id decode, giving 1-cycle latency.
  - port_id is stable for 2 cycles per KCPSM3 access, so the data is valid when read_strobe is sampled.
  - Unmapped addresses return 8'h00, never X.
- Pop:
  - read_strobe & DATA selected & !empty: advance the read pointer and decrement the count after that cycle.
  - A pop when empty returns 8'h00, sets underflow (sticky), and leaves the pointers unchanged.
- Push:
  - in_valid & !full: write in_data, increment the count.
  - in_valid & full: drop the byte and set overflow (sticky).
  - Push and pop in the same cycle: both take effect and the count is unchanged.
  - When full, a same-cycle pop does NOT admit a push, because in_ready is combinationally !full.
- Flush:
  - Pointers and count go to 0 the next cycle.
  - A same-cycle push or pop is discarded (flush wins).
  - Flush does not clear the sticky flags.
- Writes:
  - Registers update on write_strobe & address match.
  - A write affecting a flag and a same-cycle event setting it: set wins.
- Interrupt condition: cond = irq_en & ((thresh!=0 & count>=thresh) | overflow).
  - interrupt sets on the cycle after cond is true while interrupt=0.
  - It stays high until interrupt_ack, which clears it synchronously on the next edge. Ack has priority over set in the same cycle.
  - After an ack, cond is re-evaluated. If it is still true, interrupt reasserts one cycle later; the ISR must drain the FIFO or clear the flag.
  - Clearing irq_en does not drop a pending interrupt; only ack clears it.
- Count arithmetic: width clog2(DEPTH)+1; pointers wrap modulo DEPTH; the thresh compare zero-extends count to 8 bits.
- Asynchronous reset mid-transfer returns everything to reset values immediately. A pop in flight is lost.

Decomposition:
- Shared package/include (picoblaze_io_defs):
  - register offsets DATA=0, STATUS=1, COUNT=2, THRESH=3;
  - CTRL bit indices;
  - STATUS bit indices.
- One sub-module, byte_fifo_sync:
  - parameterised DEPTH;
  - push/pop/flush inputs;
  - head, count, full and empty outputs.
- The top level holds decode, registers, the read mux and interrupt logic.

Test Plan:
- Reset, then read STATUS and COUNT → 8'h01 (empty) and 8'h00; interrupt=0; in_ready=1.
- Push 0xA5,0x3C; read DATA twice → 0xA5 then 0x3C; COUNT goes 2→1→0; then a third read → 0x00 and STATUS bit6 (underflow)=1.
- Write THRESH=4, CTRL=0x01, push 4 bytes → interrupt rises 1 cycle after the 4th push is counted. Pulse interrupt_ack → interrupt drops, then reasserts 1 cycle later (count still 4). Drain 1 byte and ack → interrupt stays 0.
- DEPTH=16: push 17 bytes with in_valid held → in_ready=0 after the 16th; the 17th is dropped; STATUS=0x82 (overflow, full). Write CTRL=0x04 → overflow cleared.
- Full FIFO, pop and in_valid in the same cycle → COUNT=15 and no push accepted. Next cycle push accepted → COUNT=16.
- Push 5 bytes then write CTRL=0x02 with a simultaneous push → COUNT=0 and empty=1. Assert reset mid-sequence → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/picoblaze_rx_mailbox_pkg.sv
// Shared I/O definitions for the PicoBlaze receive mailbox: register offsets,
// CTRL write bit positions, STATUS read bit positions and the port decode helper.
package picoblaze_rx_mailbox_pkg;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_COUNT  = 2'd2,
        REG_THRESH = 2'd3
    } reg_off_e;

    // CTRL shares the STATUS address but is write-only
    localparam int CTRL_IRQ_EN  = 0;
    localparam int CTRL_FLUSH   = 1;
    localparam int CTRL_CLR_OVF = 2;
    localparam int CTRL_CLR_UDF = 3;

    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_INTERRUPT = 4;
    localparam int STAT_IRQ_EN    = 5;
    localparam int STAT_UNDERFLOW = 6;
    localparam int STAT_OVERFLOW  = 7;

    // A port block is four consecutive addresses, so only the upper six bits decode
    function automatic logic port_match(input logic [7:0] port_id, input logic [7:0] base);
        return port_id[7:2] == base[7:2];
    endfunction

endpackage

// File: rtl/picoblaze_rx_mailbox_if.sv
// KCPSM3 I/O port bus between the processor (master) and a peripheral (slave).
interface picoblaze_rx_mailbox_if;
    logic [7:0] port_id;
    logic       write_strobe;
    logic       read_strobe;
    logic [7:0] out_port;
    logic [7:0] in_port;
    logic       interrupt;
    logic       interrupt_ack;

    modport master (
        output port_id, write_strobe, read_strobe, out_port, interrupt_ack,
        input  in_port, interrupt
    );

    modport slave (
        input  port_id, write_strobe, read_strobe, out_port, interrupt_ack,
        output in_port, interrupt
    );
endinterface

// File: rtl/picoblaze_rx_mailbox_byte_fifo_sync.sv
// Synchronous byte FIFO with occupancy count; flush has priority over push and pop.
module byte_fifo_sync #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [7:0]               data_i,
    output logic [7:0]               head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // A push into a full FIFO or a pop from an empty one is simply not performed
    assign push_ok = push_i & ~full_o & ~flush_i;
    assign pop_ok  = pop_i & ~empty_o & ~flush_i;

    // Next pointers and count; pointers wrap naturally because DEPTH is a power of two
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array needs no reset; stale contents are never presented while empty
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/picoblaze_rx_mailbox.sv
// Receive mailbox peripheral for KCPSM3: buffers a fabric byte stream and exposes
// DATA/STATUS(CTRL)/COUNT/THRESH ports plus a level interrupt held until acknowledged.
module picoblaze_rx_mailbox
    import picoblaze_rx_mailbox_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR  = 8'h00,
    parameter int         DEPTH      = 16,
    parameter logic [7:0] THRESH_RST = 8'd1
) (
    input  logic                          clk,
    input  logic                          reset,
    picoblaze_rx_mailbox_if.slave         bus,
    input  logic                          in_valid,
    input  logic [7:0]                    in_data,
    output logic                          in_ready
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [7:0]    head;
    logic [CW-1:0] count;
    logic          full, empty;
    logic [7:0]    count8;
    logic          sel;
    reg_off_e      off;
    logic          rd_data, wr_ctrl, wr_thresh;
    logic          pop, flush, overflow_evt, underflow_evt, cond;
    logic [7:0]    status;

    logic       irq_en_q, irq_en_d;
    logic       overflow_q, overflow_d;
    logic       underflow_q, underflow_d;
    logic [7:0] thresh_q, thresh_d;
    logic       interrupt_q, interrupt_d;
    logic [7:0] in_port_q, in_port_d;

    assign sel       = port_match(bus.port_id, BASE_ADDR);
    assign off       = reg_off_e'(bus.port_id[1:0]);
    assign rd_data   = bus.read_strobe  & sel & (off == REG_DATA);
    assign wr_ctrl   = bus.write_strobe & sel & (off == REG_STATUS);
    assign wr_thresh = bus.write_strobe & sel & (off == REG_THRESH);

    assign pop           = rd_data & ~empty;
    assign underflow_evt = rd_data & empty;
    assign overflow_evt  = in_valid & full;
    assign flush         = wr_ctrl & bus.out_port[CTRL_FLUSH];
    assign in_ready      = ~full;
    assign count8        = 8'(count);

    byte_fifo_sync #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (in_valid),
        .pop_i   (pop),
        .flush_i (flush),
        .data_i  (in_data),
        .head_o  (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    // STATUS byte assembled from live FIFO flags and the control/flag registers
    always_comb begin
        status                 = '0;
        status[STAT_EMPTY]     = empty;
        status[STAT_FULL]      = full;
        status[STAT_INTERRUPT] = interrupt_q;
        status[STAT_IRQ_EN]    = irq_en_q;
        status[STAT_UNDERFLOW] = underflow_q;
        status[STAT_OVERFLOW]  = overflow_q;
    end

    // Next state for the read mux, control registers, sticky flags and interrupt
    always_comb begin
        in_port_d = 8'h00;
        if (sel) begin
            case (off)
                REG_DATA:   in_port_d = empty ? 8'h00 : head;
                REG_STATUS: in_port_d = status;
                REG_COUNT:  in_port_d = count8;
                REG_THRESH: in_port_d = thresh_q;
                default:    in_port_d = 8'h00;
            endcase
        end

        irq_en_d = wr_ctrl ? bus.out_port[CTRL_IRQ_EN] : irq_en_q;
        thresh_d = wr_thresh ? bus.out_port : thresh_q;

        overflow_d = overflow_q;
        if (wr_ctrl && bus.out_port[CTRL_CLR_OVF]) overflow_d = 1'b0;
        if (overflow_evt) overflow_d = 1'b1;

        underflow_d = underflow_q;
        if (wr_ctrl && bus.out_port[CTRL_CLR_UDF]) underflow_d = 1'b0;
        if (underflow_evt) underflow_d = 1'b1;

        cond = irq_en_q & (((thresh_q != 8'h00) & (count8 >= thresh_q)) | overflow_q);
        interrupt_d = interrupt_q;
        if (bus.interrupt_ack) interrupt_d = 1'b0;
        else if (cond)         interrupt_d = 1'b1;
    end

    // Register bank, all returning to reset values asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            thresh_q    <= THRESH_RST;
            interrupt_q <= 1'b0;
            in_port_q   <= 8'h00;
        end else begin
            irq_en_q    <= irq_en_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            thresh_q    <= thresh_d;
            interrupt_q <= interrupt_d;
            in_port_q   <= in_port_d;
        end
    end

    assign bus.in_port   = in_port_q;
    assign bus.interrupt = interrupt_q;

endmodule
